// File: rtl/control_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// control_sequencer
//
// Hardwired Moore control unit for the datapath. It runs the 3-cycle
// instruction fetch (T0-T2). It then decodes the opcode in IR and, for
// register-register ALU instructions, runs the 3-cycle execute (T3-T5).
// Register numbers are not decoded here. Gra/Grb/Grc only pick which IR field
// the select-and-encode logic uses.
//
// Optional feature macro: CTRL_MEMWAIT_EN
//   defined   : T1 stretches until MemRdy=1. Read and MDRin stay high for the
//               whole of T1. PCin and Zlowout pulse only in the first T1 cycle.
//   undefined : T1 is a single cycle and MemRdy is ignored.
//
// Parameters
//   IRW   instruction register width
//   OPW   opcode field width, taken from IR[IRW-1 -: OPW]
//
// Ports
//   clk                          system clock, rising edge
//   clr                          asynchronous active-high reset
//   Run                          start/continue; sampled in IDLE and at end of instruction
//   IR                           instruction register contents (valid from T3)
//   MemRdy                       memory read complete (CTRL_MEMWAIT_EN only)
//   PCout,Zlowout,MDRout,Rout    bus drive enables
//   MARin,PCin,MDRin,IRin,
//   Yin,Zin,Rin                  register load enables
//   IncPC,Read                   PC+1 in ALU; memory read request
//   ADD,SUB,AND,OR               ALU op select (one-hot or zero)
//   Gra,Grb,Grc                  ra/rb/rc field select
//   Halted                       high in HALT state
// -----------------------------------------------------------------------------
module control_sequencer #(
    parameter int IRW = 32,
    parameter int OPW = 5
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           Run,
    input  logic [IRW-1:0] IR,
    input  logic           MemRdy,
    output logic           PCout,
    output logic           Zlowout,
    output logic           MDRout,
    output logic           Rout,
    output logic           MARin,
    output logic           PCin,
    output logic           MDRin,
    output logic           IRin,
    output logic           Yin,
    output logic           Zin,
    output logic           Rin,
    output logic           IncPC,
    output logic           Read,
    output logic           ADD,
    output logic           SUB,
    output logic           AND,
    output logic           OR,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           Halted
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6,
        S_HALT = 3'd7
    } state_t;

    localparam logic [OPW-1:0] OP_NOP  = '0;
    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic [OPW-1:0] ir_op;
    logic           ir_is_alu;
    logic           first_t1;    // PCin/Zlowout only in the first T1 cycle
    logic           unused_bits;

    assign ir_op     = IR[IRW-1 -: OPW];
    assign ir_is_alu = (ir_op == OP_ADD) || (ir_op == OP_SUB) ||
                       (ir_op == OP_AND) || (ir_op == OP_OR);

`ifdef CTRL_MEMWAIT_EN
    // Set once T1 has been held for at least one edge. It blanks the
    // PC-update strobes so the PC is loaded only once per fetch.
    logic wait_q, wait_d;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) wait_q <= 1'b0;
        else     wait_q <= wait_d;
    end

    assign first_t1    = ~wait_q;
    assign unused_bits = ^IR[IRW-OPW-1:0];
`else
    assign first_t1    = 1'b1;
    assign unused_bits = ^{IR[IRW-OPW-1:0], MemRdy};
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Next-state logic. The opcode is decoded straight from IR in T3 (IR was
    // loaded at the end of T2) and latched on the same edge for use in T4.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
`ifdef CTRL_MEMWAIT_EN
        wait_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: if (Run) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1: begin
`ifdef CTRL_MEMWAIT_EN
                if (MemRdy) state_d = S_T2;
                else        wait_d  = 1'b1;
`else
                state_d = S_T2;
`endif
            end
            S_T2:   state_d = S_T3;
            S_T3: begin
                op_d = ir_op;
                if (ir_is_alu)              state_d = S_T4;
                else if (ir_op == OP_HALT)  state_d = S_HALT;
                else                        state_d = Run ? S_T0 : S_IDLE;
            end
            S_T4:   state_d = S_T5;
            S_T5:   state_d = Run ? S_T0 : S_IDLE;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs: present state and latched opcode only.
    always_comb begin
        PCout   = 1'b0;
        Zlowout = 1'b0;
        MDRout  = 1'b0;
        Rout    = 1'b0;
        MARin   = 1'b0;
        PCin    = 1'b0;
        MDRin   = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Zin     = 1'b0;
        Rin     = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        ADD     = 1'b0;
        SUB     = 1'b0;
        AND     = 1'b0;
        OR      = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        Halted  = 1'b0;
        case (state_q)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                Zlowout = first_t1;
                PCin    = first_t1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                Grb  = 1'b1;
                Rout = 1'b1;
                Yin  = 1'b1;
            end
            S_T4: begin
                Grc  = 1'b1;
                Rout = 1'b1;
                Zin  = 1'b1;
                ADD  = (op_q == OP_ADD);
                SUB  = (op_q == OP_SUB);
                AND  = (op_q == OP_AND);
                OR   = (op_q == OP_OR);
            end
            S_T5: begin
                Zlowout = 1'b1;
                Gra     = 1'b1;
                Rin     = 1'b1;
            end
            S_HALT: Halted = 1'b1;
            default: ;
        endcase
    end

endmodule
